// File: rtl/gfm_mac_engine_if.sv
// Operand-in / result-out handshake bundle for the GF(2) MAC engine.
// A transfer completes on any rising edge where valid and ready are both high.
// The producer holds its payload stable while valid is high and ready is low.
// A producer never waits for ready before raising valid.
interface gfm_mac_engine_if #(
  parameter int M = 32,
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] col_a;
  logic [N-1:0] row_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_row;
  logic         out_last;

  modport master (
    output in_valid, col_a, row_b, out_ready,
    input  in_ready, out_valid, out_row, out_last
  );

  modport slave (
    input  in_valid, col_a, row_b, out_ready,
    output in_ready, out_valid, out_row, out_last
  );
endinterface

// File: rtl/gfm_mac_engine.sv
// GF(2) matrix multiply-accumulate: XOR-accumulates K outer products col_a x row_b
// into an M x N bit array, then drains it one row per handshake.
module gfm_mac_engine #(
  parameter int M  = 32,
  parameter int N  = 32,
  parameter int KW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          acc_mode,
  gfm_mac_engine_if.slave bus,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state_dbg
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [KW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          done_q;
  logic [N-1:0]  acc [M];

  logic beat_hs;
  logic row_hs;

  assign bus.in_ready  = clk_en && (state == ACCUM);
  assign bus.out_valid = clk_en && (state == DRAIN);
  assign bus.out_row   = acc[idx];
  assign bus.out_last  = bus.out_valid && (idx == LAST_IDX);

  assign beat_hs = bus.in_valid && bus.in_ready;
  assign row_hs  = bus.out_valid && bus.out_ready;

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign state_dbg = state;

  // Handshake terms already include clk_en, so a low clk_en holds everything
  // except the done pulse, which simply drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < M; i++) begin
        acc[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start && clk_en) begin
            cnt <= k_len;
            idx <= '0;
            if (!acc_mode) begin
              for (int i = 0; i < M; i++) begin
                acc[i] <= '0;
              end
            end
            state <= (k_len != '0) ? ACCUM : DRAIN;
          end
        end

        ACCUM: begin
          if (beat_hs) begin
            for (int i = 0; i < M; i++) begin
              if (bus.col_a[i]) begin
                acc[i] <= acc[i] ^ bus.row_b;
              end
            end
            cnt <= cnt - KW'(1);
            if (cnt == KW'(1)) begin
              state <= DRAIN;
              idx   <= '0;
            end
          end
        end

        DRAIN: begin
          // Drain leaves acc untouched so an acc_mode=1 job can build on it.
          if (row_hs) begin
            if (idx == LAST_IDX) begin
              state  <= IDLE;
              idx    <= '0;
              done_q <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfm_mac_engine.sv
// Directed bench for gfm_mac_engine at M=N=4 with hand-computed result rows.
module tb_gfm_mac_engine;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int KW = 6;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clk_en = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          acc_mode = 1'b0;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  gfm_mac_engine_if #(.M(M), .N(N)) bus ();

  gfm_mac_engine #(.M(M), .N(N), .KW(KW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .start     (start),
    .k_len     (k_len),
    .acc_mode  (acc_mode),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int           errors = 0;
  int           checks = 0;
  logic [N-1:0] exp_q [$];
  logic [N-1:0] got_q [$];
  bit           last_q [$];
  logic [M-1:0] beat_a [$];
  logic [N-1:0] beat_b [$];
  bit           beat_to = 1'b0;
  bit           done_after;
  int           done_cyc;

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic start_job(input logic [KW-1:0] k, input bit am, output int t);
    start = 1'b1; k_len = k; acc_mode = am;
    @(posedge clk); #1;
    t = cyc;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [M-1:0] a, input logic [N-1:0] b, input bit gaps);
    int g = gaps ? int'($urandom_range(0, 2)) : 0;
    int n = 0;
    repeat (g) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1; bus.col_a = a; bus.row_b = b;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) beat_to = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int nrows, input bit gaps, output bit to);
    int n = 0;
    int target = got_q.size() + nrows;
    while (got_q.size() < target && n < 200) begin
      bus.out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_row);
        last_q.push_back(bus.out_last);
      end
      @(posedge clk); #1;
      n++;
    end
    bus.out_ready = 1'b0;
    to = (got_q.size() < target);
    done_after = done;
    done_cyc = cyc;
  endtask

  task automatic run_job(input logic [KW-1:0] k, input bit am, input bit gaps,
                         output bit to, output int t);
    start_job(k, am, t);
    for (int i = 0; i < beat_a.size(); i++) send_beat(beat_a[i], beat_b[i], gaps);
    got_q.delete(); last_q.delete();
    collect(M, gaps, to);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++; $display("FAIL reset_hs: in_ready=%b out_valid=%b out_last=%b want 0", bus.in_ready, bus.out_valid, bus.out_last); end
    checks++; if (bus.out_row !== 4'b0000) begin
      errors++; $display("FAIL reset_row: got %b want 0000", bus.out_row); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin
      errors++; $display("FAIL reset_ctl: busy=%b done=%b state=%0d want 0/0/0", busy, done, state_dbg); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int t; bit to;
    start_job(6'd1, 1'b0, t);
    checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL single_start: busy=%b in_ready=%b want 1/1", busy, bus.in_ready); end
    send_beat(4'b0101, 4'b1011, 1'b0);
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL single_turn: in_ready=%b out_valid=%b want 0/1", bus.in_ready, bus.out_valid); end
    got_q.delete(); last_q.delete();
    collect(M, 1'b0, to);
    exp_q = '{4'b1011, 4'b0000, 4'b1011, 4'b0000};
    checks++; if (to || got_q.size() != M) begin
      errors++; $display("FAIL single_count: got %0d rows want %0d", got_q.size(), M); end
    for (int r = 0; r < got_q.size(); r++) begin
      checks++; if (got_q[r] !== exp_q[r] || last_q[r] !== (r == M - 1)) begin
        errors++; $display("FAIL single_row%0d: got %b last=%b want %b last=%b", r, got_q[r], last_q[r], exp_q[r], r == M - 1); end
    end
    checks++; if (done_after !== 1'b1) begin
      errors++; $display("FAIL single_done: got %b want 1", done_after); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_pulse: done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_accum_cancel();
    int t; bit to;
    beat_a = '{4'b0101}; beat_b = '{4'b1011};
    run_job(6'd1, 1'b1, 1'b0, to, t);
    checks++; if (to || got_q.size() != M) begin
      errors++; $display("FAIL cancel_count: got %0d rows want %0d", got_q.size(), M); end
    for (int r = 0; r < got_q.size(); r++) begin
      checks++; if (got_q[r] !== 4'b0000) begin
        errors++; $display("FAIL cancel_row%0d: got %b want 0000", r, got_q[r]); end
    end
    run_job(6'd1, 1'b0, 1'b0, to, t);
    exp_q = '{4'b1011, 4'b0000, 4'b1011, 4'b0000};
    checks++; if (to || got_q.size() != M) begin
      errors++; $display("FAIL clear_count: got %0d rows want %0d", got_q.size(), M); end
    for (int r = 0; r < got_q.size(); r++) begin
      checks++; if (got_q[r] !== exp_q[r]) begin
        errors++; $display("FAIL clear_row%0d: got %b want %b", r, got_q[r], exp_q[r]); end
    end
  endtask

  task automatic test_identity();
    int t; bit to;
    beat_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    beat_b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    run_job(6'd4, 1'b0, 1'b0, to, t);
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    checks++; if (to || got_q.size() != M) begin
      errors++; $display("FAIL ident_count: got %0d rows want %0d", got_q.size(), M); end
    for (int r = 0; r < got_q.size(); r++) begin
      checks++; if (got_q[r] !== exp_q[r] || last_q[r] !== (r == M - 1)) begin
        errors++; $display("FAIL ident_row%0d: got %b last=%b want %b", r, got_q[r], last_q[r], exp_q[r]); end
    end
    // start sampled at edge t; done high after edge t+8, i.e. cycle start+9.
    checks++; if (done_after !== 1'b1 || (done_cyc - t) != 8) begin
      errors++; $display("FAIL ident_latency: done=%b after %0d edges want 1 after 8", done_after, done_cyc - t); end
  endtask

  task automatic test_k_zero();
    int t; bit to;
    beat_a.delete(); beat_b.delete();
    start_job(6'd0, 1'b1, t);
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL kzero_turn: in_ready=%b out_valid=%b want 0/1", bus.in_ready, bus.out_valid); end
    got_q.delete(); last_q.delete();
    collect(M, 1'b0, to);
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    checks++; if (to || got_q.size() != M) begin
      errors++; $display("FAIL kzero_acc_count: got %0d rows want %0d", got_q.size(), M); end
    for (int r = 0; r < got_q.size(); r++) begin
      checks++; if (got_q[r] !== exp_q[r]) begin
        errors++; $display("FAIL kzero_acc_row%0d: got %b want %b", r, got_q[r], exp_q[r]); end
    end
    run_job(6'd0, 1'b0, 1'b0, to, t);
    checks++; if (to || got_q.size() != M) begin
      errors++; $display("FAIL kzero_clr_count: got %0d rows want %0d", got_q.size(), M); end
    for (int r = 0; r < got_q.size(); r++) begin
      checks++; if (got_q[r] !== 4'b0000) begin
        errors++; $display("FAIL kzero_clr_row%0d: got %b want 0000", r, got_q[r]); end
    end
  endtask

  task automatic test_stalls();
    int t; bit to; bit to2; bit bad_in = 1'b0; bit bad_out = 1'b0;
    beat_a = '{4'b0011, 4'b1100, 4'b1010, 4'b0101};
    beat_b = '{4'b0110, 4'b1001, 4'b1111, 4'b0001};
    start_job(6'd4, 1'b0, t);
    send_beat(beat_a[0], beat_b[0], 1'b1);
    send_beat(beat_a[1], beat_b[1], 1'b1);
    clk_en = 1'b0;
    bus.in_valid = 1'b1; bus.col_a = beat_a[2]; bus.row_b = beat_b[2];
    repeat (3) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || state_dbg !== 2'd1) bad_in = 1'b1;
      @(posedge clk); #1;
    end
    clk_en = 1'b1; bus.in_valid = 1'b0;
    checks++; if (bad_in) begin
      errors++; $display("FAIL stall_accum: in_ready or state moved while clk_en=0 (want in_ready=0 state=1)"); end
    send_beat(beat_a[2], beat_b[2], 1'b1);
    send_beat(beat_a[3], beat_b[3], 1'b1);
    got_q.delete(); last_q.delete();
    collect(2, 1'b1, to);
    start = 1'b1; k_len = 6'd1; acc_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (state_dbg !== 2'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL drain_start: state=%0d busy=%b want 2/1", state_dbg, busy); end
    clk_en = 1'b0; bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd2) bad_out = 1'b1;
      @(posedge clk); #1;
    end
    clk_en = 1'b1; bus.out_ready = 1'b0;
    checks++; if (bad_out) begin
      errors++; $display("FAIL stall_drain: out_valid/done/state moved while clk_en=0 (want 0/0/2)"); end
    collect(2, 1'b1, to2);
    exp_q = '{4'b0111, 4'b1001, 4'b1000, 4'b0110};
    checks++; if (to || to2 || beat_to || got_q.size() != M) begin
      errors++; $display("FAIL stall_count: got %0d rows timeout=%0b want %0d", got_q.size(), to || to2 || beat_to, M); end
    for (int r = 0; r < got_q.size(); r++) begin
      checks++; if (got_q[r] !== exp_q[r] || last_q[r] !== (r == M - 1)) begin
        errors++; $display("FAIL stall_row%0d: got %b last=%b want %b", r, got_q[r], last_q[r], exp_q[r]); end
    end
    checks++; if (done_after !== 1'b1) begin
      errors++; $display("FAIL stall_done: got %b want 1", done_after); end
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL stall_ignored_start: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int t; bit to;
    start_job(6'd4, 1'b0, t);
    send_beat(4'b0001, 4'b0001, 1'b0);
    send_beat(4'b0010, 4'b0010, 1'b0);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctl: busy=%b done=%b state=%0d in_ready=%b want 0", busy, done, state_dbg, bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_row !== 4'b0000) begin
      errors++; $display("FAIL rstmid_out: out_valid=%b out_last=%b out_row=%b want 0", bus.out_valid, bus.out_last, bus.out_row); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    beat_a.delete(); beat_b.delete();
    run_job(6'd0, 1'b1, 1'b0, to, t);
    checks++; if (to || got_q.size() != M) begin
      errors++; $display("FAIL rstmid_count: got %0d rows want %0d", got_q.size(), M); end
    for (int r = 0; r < got_q.size(); r++) begin
      checks++; if (got_q[r] !== 4'b0000) begin
        errors++; $display("FAIL rstmid_row%0d: got %b want 0000", r, got_q[r]); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.col_a = '0; bus.row_b = '0; bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_accum_cancel();
    test_identity();
    test_k_zero();
    test_stalls();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gfm_mac_engine.md
# gfm_mac_engine

Sequenced GF(2) matrix multiply-accumulate engine: computes C = A·B over GF(2) as K XOR-accumulated outer products of column vectors of A (M bits) and row vectors of B (N bits). It adds M/N/K parametrisation, valid/ready handshakes on input and output, and a control FSM that counts K beats, then drains the M×N result row by row. It optionally retains the previous result as an accumulation seed. It sits between the operand fetch path and the result write-back path of the GF(2) coprocessor.

## Interface
- M, 32, rows of result (width of col_a; number of drained rows)
- N, 32, columns of result (width of row_b and out_row)
- KW, 6, width of k_len (max K = 2^KW − 1)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- clk_en  input  1  global enable; 0 freezes all state, in_ready and out_valid forced 0
- start  input  1  begin a job; sampled only in IDLE with clk_en=1
- k_len  input  KW  number of outer-product beats for the job, sampled with start
- acc_mode  input  1  sampled with start; 0 = clear array first, 1 = accumulate onto retained result
- in_valid  input  1  operand beat valid
- in_ready  output  1  engine accepts a beat (ACCUM state and clk_en)
- col_a  input  M  column i of A for the beat
- row_b  input  N  row i of B for the beat
- out_valid  output  1  out_row valid (DRAIN state and clk_en)
- out_ready  input  1  downstream accepts row
- out_row  output  N  result row at current drain index
- out_last  output  1  high with out_valid on row M−1
- busy  output  1  state ≠ IDLE
- done  output  1  one-cycle pulse after final row handshake

## Operation
- Storage: acc[0..M−1], N bits each; beat counter (KW bits); row index (clog2(M) bits, min 1).
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE: start & clk_en → latch k_len into counter; if acc_mode=0 clear all acc rows; next state ACCUM if k_len≠0, else DRAIN. start outside IDLE ignored.
- ACCUM: beat accepted when in_valid & in_ready. For each i: acc[i] ← acc[i] XOR (col_a[i] ? row_b : 0). Counter decrements; acceptance of the beat bringing counter to 0 → DRAIN, row index ← 0.
- DRAIN: out_row = acc[row index] (combinational mux of registered array); handshake out_valid & out_ready advances the index; handshake on row M−1 → IDLE, done=1 next cycle. Drain non-destructive: acc retained for next acc_mode=1 job.
- clk_en=0: no state, counter, index or array change; no handshakes complete; done not asserted.
- Arithmetic: pure XOR/AND, no carries; no width growth.

## Timing
- Reset (async assert, sync release): state IDLE, acc all 0, counter 0, index 0; in_ready=0, out_valid=0, out_last=0, out_row=0, busy=0, done=0.
- start at edge t → busy and in_ready high from cycle t+1.
- Accepted beat at edge t reflected in acc from t+1.
- Last beat at edge t → out_valid high in cycle t+1 (1-cycle turnaround); in_ready low in t+1.
- Sustained throughput: 1 beat/cycle in, 1 row/cycle out with ready held high.
- Total job with no stalls: 1 + K + M cycles start-to-done pulse.
- out_row/out_last stable while out_valid & !out_ready.
- Reset asserted mid-job: immediate abort to reset values; partial result discarded.

## Test plan
- M=N=4, acc_mode=0, k_len=1, col_a=4'b0101, row_b=4'b1011 → rows 0..3 = 1011,0000,1011,0000; out_last only on row 3; done one cycle after row 3.
- M=N=4, k_len=4, beat k: col_a=1<<k, row_b=1<<k → identity: out_row[r]=1<<r for r=0..3; done at cycle start+9 with no stalls.
- Repeat first test with acc_mode=1 → all four rows 0000 (XOR cancellation); then acc_mode=0, same beat → 1011,0000,1011,0000 again.
- k_len=0, acc_mode=0 → no in_ready, immediate DRAIN of four 0000 rows; k_len=0, acc_mode=1 after identity job → re-drains identity.
- Random in_valid/out_ready gaps plus clk_en low for 3 cycles mid-ACCUM and mid-DRAIN → results identical to unstalled run; no beat lost or duplicated; start pulsed during DRAIN ignored.
- reset low during ACCUM after 2 of 4 beats → all outputs 0 immediately; new job acc_mode=1, k_len=0 drains 0000 rows.
